// File: rtl/os_xor_slice_acc.sv
// os_xor_slice_acc: folds a stream of narrow XOR-of-partial-product slices
// into one wide carry-less product share per frame, presented on a
// valid/ready output with backpressure.
module os_xor_slice_acc #(
  parameter int SLICE_W    = 7,
  parameter int NUM_SLICES = 4,
  parameter int SHIFT      = 4,
  parameter int ACC_W      = SLICE_W + SHIFT*(NUM_SLICES-1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SLICE_W-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [7:0]       frames_done
);

  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES-1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] shifted;
  logic             accept;

  // Slice positioned at its frame offset; idx is already 0 while in HOLD,
  // so a HOLD-cycle accept lands as slice 0 of the next frame.
  always_comb begin
    shifted = ACC_W'(in_y) << (SHIFT * int'(idx));
  end

  // Flush blocks intake for its cycle; HOLD passes consumer readiness
  // through so the next frame can start in the same cycle as the handshake.
  always_comb begin
    in_ready = !flush && ((state == ACCUM) || out_ready);
    accept   = in_valid && in_ready;
  end

  assign out_valid = (state == HOLD);

  // Frame accumulation, output register, delivery counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      idx         <= '0;
      acc         <= '0;
      out_data    <= '0;
      frames_done <= '0;
    end else if (flush) begin
      // Discards any partial frame and any unconsumed result; the counter
      // only tracks frames actually delivered, so it is left alone.
      state <= ACCUM;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              out_data <= acc ^ shifted;
              idx      <= '0;
              state    <= HOLD;
            end else begin
              acc <= (idx == '0) ? shifted : (acc ^ shifted);
              idx <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            frames_done <= frames_done + 8'd1;
            state       <= ACCUM;
            if (accept) begin
              acc <= shifted;
              idx <= IDX_W'(1);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
